// File: rtl/led_pattern_gen.sv
// WIDTH-bit LED pattern sequencer: a prescaler produces one tick every DIV enabled
// cycles, and each tick either advances the active pattern or seeds a newly selected one.
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 25_000_000,
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    typedef enum logic [1:0] {
        MODE_ROL  = 2'd0,
        MODE_ROR  = 2'd1,
        MODE_PING = 2'd2,
        MODE_CNT  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(DIV - 1);
    localparam logic [WIDTH-1:0] SEED_LSB   = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_MSB   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] led_q, led_d;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic             step_q, step_d;
    logic             tick;
    mode_e            mode_in;

    assign mode_in = mode_e'(mode);
    assign tick    = en && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d = presc_q;
        led_d   = led_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        step_d  = tick;

        if (en) begin
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
        end

        // A tick with a different mode selected only loads that mode's seed.
        if (tick) begin
            if (mode_in != mode_q) begin
                mode_d = mode_in;
                case (mode_in)
                    MODE_ROL:  led_d = SEED_LSB;
                    MODE_ROR:  led_d = SEED_MSB;
                    MODE_PING: begin
                        led_d = SEED_LSB;
                        dir_d = DIR_LEFT;
                    end
                    MODE_CNT:  led_d = '0;
                    default:   led_d = SEED_LSB;
                endcase
            end else begin
                case (mode_q)
                    MODE_ROL:  led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                    MODE_ROR:  led_d = {led_q[0], led_q[WIDTH-1:1]};
                    MODE_PING: begin
                        // Turning around at an end moves away immediately, so ends never repeat.
                        if (dir_q == DIR_LEFT && led_q[WIDTH-1]) begin
                            dir_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else if (dir_q == DIR_RIGHT && led_q[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = led_q << 1;
                        end else if (dir_q == DIR_LEFT) begin
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                    MODE_CNT:  led_d = led_q + WIDTH'(1);
                    default:   led_d = led_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            led_q   <= SEED_LSB;
            mode_q  <= MODE_ROL;
            dir_q   <= DIR_LEFT;
            step_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: one 4-bit instance with DIV=4 for the pattern,
// gating and reset steps, and one 4-bit instance with DIV=1 for the counter wrap.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       reset_a, en_a;
    logic [1:0] mode_a;
    logic [3:0] led_a;
    logic       step_a;
    logic       reset_b, en_b;
    logic [1:0] mode_b;
    logic [3:0] led_b;
    logic       step_b;

    int checks = 0;
    int errors = 0;

    led_pattern_gen #(.WIDTH(4), .DIV(4), .CNT_W(3)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .en    (en_a),
        .mode  (mode_a),
        .led   (led_a),
        .step  (step_a)
    );

    led_pattern_gen #(.WIDTH(4), .DIV(1), .CNT_W(1)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .en    (en_b),
        .mode  (mode_b),
        .led   (led_b),
        .step  (step_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Count cycles until dut_a pulses step, giving up after the budget.
    task automatic wait_step_a(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            cycle();
            n++;
            if (step_a === 1'b1) return;
        end
        n = budget + 1;
    endtask

    initial begin
        int         n;
        int         bad;
        logic [3:0] exp_ping [7];
        logic [3:0] exp_rol  [4];

        exp_rol  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_ping = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

        reset_a = 1'b1; en_a = 1'b0; mode_a = 2'd0;
        reset_b = 1'b1; en_b = 1'b0; mode_b = 2'd0;
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;
        #1;
        check("reset_led", 32'(led_a), 32'h1);
        check("reset_step", 32'(step_a), 32'h0);

        // Idle with en low for 20 cycles.
        cycle();
        reset_a = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (step_a !== 1'b0 || led_a !== 4'b0001) bad++;
        end
        check("idle_hold", 32'(bad), 32'h0);

        // Rotate-left: first change 4 cycles after enabling, later ones 3 after the pulse-low check.
        en_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_step_a(10, n);
            check("rol_period", 32'(n), (i == 0) ? 32'd4 : 32'd3);
            check("rol_led", 32'(led_a), 32'(exp_rol[i]));
            cycle();
            check("rol_step_width", 32'(step_a), 32'h0);
        end

        // Ping-pong: the first tick after selecting mode 2 only seeds.
        mode_a = 2'd2;
        wait_step_a(10, n);
        check("ping_seed_period", 32'(n), 32'd3);
        check("ping_seed_led", 32'(led_a), 32'h1);
        for (int i = 0; i < 7; i++) begin
            cycle();
            wait_step_a(10, n);
            check("ping_period", 32'(n), 32'd3);
            check("ping_led", 32'(led_a), 32'(exp_ping[i]));
        end

        // Enable gating with the prescaler at 2.
        cycle();
        cycle();
        en_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (step_a !== 1'b0 || led_a !== 4'b0010) bad++;
        end
        check("gate_hold", 32'(bad), 32'h0);
        en_a = 1'b1;
        wait_step_a(10, n);
        check("gate_resume_period", 32'(n), 32'd2);
        check("gate_resume_led", 32'(led_a), 32'b0100);

        // Dropping en exactly on the tick cycle holds the prescaler at DIV-1.
        cycle();
        cycle();
        cycle();
        en_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (step_a !== 1'b0 || led_a !== 4'b0100) bad++;
        end
        check("tick_suppress_hold", 32'(bad), 32'h0);
        en_a = 1'b1;
        wait_step_a(10, n);
        check("tick_suppress_period", 32'(n), 32'd1);
        check("tick_suppress_led", 32'(led_a), 32'b1000);

        // Rotate-right: seed 1000, then 0100.
        cycle();
        mode_a = 2'd1;
        wait_step_a(10, n);
        check("ror_seed_led", 32'(led_a), 32'b1000);
        cycle();
        wait_step_a(10, n);
        check("ror_led", 32'(led_a), 32'b0100);

        // Async reset pulsed between edges while step is high.
        #2;
        reset_a = 1'b0;
        #1;
        check("async_reset_led", 32'(led_a), 32'h1);
        check("async_reset_step", 32'(step_a), 32'h0);
        #1;
        reset_a = 1'b1;
        wait_step_a(10, n);
        check("post_reset_period", 32'(n), 32'd4);
        check("post_reset_seed", 32'(led_a), 32'b1000);

        // Counter wrap on the DIV=1 instance.
        cycle();
        reset_b = 1'b1;
        mode_b  = 2'd3;
        en_b    = 1'b1;
        cycle();
        check("cnt_seed_led", 32'(led_b), 32'h0);
        check("cnt_seed_step", 32'(step_b), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            cycle();
            check("cnt_led", 32'(led_b), 32'(i % 16));
            check("cnt_step", 32'(step_b), 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
